// File: rtl/aexm_pkg.sv
// Shared instruction-word layout and fetch address types for the AEXM front end.
// Latency: none (types and constants only).
// Backpressure: n/a.
package aexm_pkg;

  localparam int INSN_W  = 32;
  localparam int ADR_W   = 30;

  // Decode field positions within an instruction word
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = 6;
  localparam int RD_LSB  = 21;
  localparam int RA_LSB  = 16;
  localparam int RB_LSB  = 11;
  localparam int REG_W   = 5;
  localparam int ALT_LSB = 0;
  localparam int ALT_W   = 11;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  typedef logic [INSN_W-1:0] insn_t;
  typedef logic [ADR_W-1:0]  wadr_t;

  // One prefetch queue entry: the word plus the address it came from
  typedef struct packed {
    wadr_t adr;
    insn_t dat;
  } fq_ent_t;

endpackage

// File: rtl/aexm_fetchq_fifo.sv
// Prefetch queue storage: circular buffer of {address, word} with flush.
// Latency: a pushed entry is visible on rd_ent the cycle after the push.
// Backpressure: none internally; the caller keeps push off when full and pop off when empty.
module aexm_fetchq_fifo
  import aexm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fq_ent_t                  wr_ent,
  output fq_ent_t                  rd_ent,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fq_ent_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  // Pointer and occupancy update; flush wins over any push/pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
      else if (!push && pop) cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  // Pointer/count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until covered by the count
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_ent;
  end

  assign count  = cnt_q;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (PTR_W+1)'(DEPTH));
  assign rd_ent = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/aexm_fetchq.sv
// Instruction prefetch queue with single-outstanding bus fetch, branch flush and decode registers.
// Latency: target on iwb_adr one cycle after x_bra (idle bus); acked word on xIREG one cycle after iwb_ack.
// Backpressure: stops requesting once queued + in-flight words would exceed DEPTH; d_en drains the head.
module aexm_fetchq
  import aexm_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [29:0] RST_VEC = 30'h0
) (
  input  logic        gclk,
  input  logic        grst,
  output logic        iwb_stb,
  output logic [29:0] iwb_adr,
  input  logic        iwb_ack,
  input  logic [31:0] iwb_dat,
  input  logic        d_en,
  input  logic        x_bra,
  input  logic [29:0] x_tgt,
  output logic [31:0] xIREG,
  output logic        xVALID,
  output logic [5:0]  rOPC,
  output logic [4:0]  rRD,
  output logic [4:0]  rRA,
  output logic [4:0]  rRB,
  output logic [10:0] rALT,
  output logic [15:0] rIMM,
  output logic [29:0] rPC,
  output logic        rSKIP
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic    stb_q, stb_d;
  wadr_t   adr_q, adr_d;
  wadr_t   pc_q, pc_d;
  logic    drop_q, drop_d;
  insn_t   ir_q, ir_d;
  wadr_t   rpc_q, rpc_d;
  logic    skip_q, skip_d;

  logic             acked;
  logic             fq_push, fq_pop, fq_full, fq_empty;
  logic [CNT_W-1:0] fq_count, cnt_nxt;
  fq_ent_t          fq_wr, fq_head;

  // Only an ack against our own live request counts; stray acks are ignored
  assign acked   = stb_q & iwb_ack;
  assign fq_push = acked & ~drop_q & ~x_bra & ~fq_full;
  assign fq_pop  = d_en & ~fq_empty & ~x_bra;
  assign fq_wr   = '{adr: adr_q, dat: iwb_dat};

  aexm_fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (gclk),
    .rst_n  (grst),
    .flush  (x_bra),
    .push   (fq_push),
    .pop    (fq_pop),
    .wr_ent (fq_wr),
    .rd_ent (fq_head),
    .count  (fq_count),
    .full   (fq_full),
    .empty  (fq_empty)
  );

  // Queue occupancy as it will be after this edge, used to decide a new request
  always_comb begin
    cnt_nxt = fq_count;
    if (x_bra)                  cnt_nxt = '0;
    else if (fq_push && !fq_pop) cnt_nxt = fq_count + CNT_W'(1);
    else if (!fq_push && fq_pop) cnt_nxt = fq_count - CNT_W'(1);
  end

  // Fetch control: hold request until ack, retarget on branch, drop a stale in-flight word
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    stb_d  = 1'b0;
    adr_d  = adr_q;
    if (x_bra)        pc_d = x_tgt;
    else if (fq_push) pc_d = pc_q + 30'd1;
    if (acked)                drop_d = 1'b0;
    else if (x_bra && stb_q)  drop_d = 1'b1;
    if (stb_q && !iwb_ack) begin
      stb_d = 1'b1;
    end else if (!drop_d && (cnt_nxt < CNT_W'(DEPTH))) begin
      stb_d = 1'b1;
      adr_d = pc_d;
    end
  end

  // Decode slot: branch forces a bubble, d_en takes the head or records a bubble
  always_comb begin
    ir_d   = ir_q;
    rpc_d  = rpc_q;
    skip_d = skip_q;
    if (x_bra) begin
      skip_d = 1'b1;
    end else if (d_en) begin
      if (fq_empty) begin
        skip_d = 1'b1;
      end else begin
        ir_d   = fq_head.dat;
        rpc_d  = fq_head.adr;
        skip_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      stb_q  <= 1'b0;
      adr_q  <= RST_VEC;
      pc_q   <= RST_VEC;
      drop_q <= 1'b0;
      ir_q   <= '0;
      rpc_q  <= '0;
      skip_q <= 1'b1;
    end else begin
      stb_q  <= stb_d;
      adr_q  <= adr_d;
      pc_q   <= pc_d;
      drop_q <= drop_d;
      ir_q   <= ir_d;
      rpc_q  <= rpc_d;
      skip_q <= skip_d;
    end
  end

  assign iwb_stb = stb_q;
  assign iwb_adr = adr_q;
  assign xIREG   = fq_head.dat;
  assign xVALID  = ~fq_empty;
  assign rOPC    = ir_q[OPC_LSB +: OPC_W];
  assign rRD     = ir_q[RD_LSB +: REG_W];
  assign rRA     = ir_q[RA_LSB +: REG_W];
  assign rRB     = ir_q[RB_LSB +: REG_W];
  assign rALT    = ir_q[ALT_LSB +: ALT_W];
  assign rIMM    = ir_q[IMM_LSB +: IMM_W];
  assign rPC     = rpc_q;
  assign rSKIP   = skip_q;

endmodule

// File: tb/tb_aexm_fetchq.sv
// Bench for aexm_fetchq: directed scenarios plus a randomized run against a queue-based model.
// Latency: n/a.
// Backpressure: bench acks requests on its own schedule.
module tb_aexm_fetchq;

  localparam int DEPTH = 4;

  logic        gclk = 1'b0;
  logic        grst;
  logic        iwb_stb;
  logic [29:0] iwb_adr;
  logic        iwb_ack;
  logic [31:0] iwb_dat;
  logic        d_en;
  logic        x_bra;
  logic [29:0] x_tgt;
  logic [31:0] xIREG;
  logic        xVALID;
  logic [5:0]  rOPC;
  logic [4:0]  rRD, rRA, rRB;
  logic [10:0] rALT;
  logic [15:0] rIMM;
  logic [29:0] rPC;
  logic        rSKIP;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  always #5 gclk = ~gclk;

  // Memory image: every word is a distinct function of its address
  function automatic logic [31:0] wdat(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h9E37_79B9;
  endfunction

  assign iwb_dat = wdat(iwb_adr);

  aexm_fetchq #(.DEPTH(DEPTH), .RST_VEC(30'h0)) dut (
    .gclk(gclk), .grst(grst),
    .iwb_stb(iwb_stb), .iwb_adr(iwb_adr), .iwb_ack(iwb_ack), .iwb_dat(iwb_dat),
    .d_en(d_en), .x_bra(x_bra), .x_tgt(x_tgt),
    .xIREG(xIREG), .xVALID(xVALID),
    .rOPC(rOPC), .rRD(rRD), .rRA(rRA), .rRB(rRB), .rALT(rALT), .rIMM(rIMM),
    .rPC(rPC), .rSKIP(rSKIP)
  );

  // Apply inputs for one rising edge, then return them to idle at the following falling edge
  task automatic step(input logic d, input logic b, input logic [29:0] t, input logic a);
    d_en = d; x_bra = b; x_tgt = t; iwb_ack = a;
    @(negedge gclk);
    d_en = 1'b0; x_bra = 1'b0; iwb_ack = 1'b0;
  endtask

  task automatic test_reset();
    grst = 1'b0; d_en = 1'b0; x_bra = 1'b0; x_tgt = '0; iwb_ack = 1'b1;
    repeat (3) @(negedge gclk);
    checks++; if (iwb_stb !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b want 0", iwb_stb); end
    checks++; if (xVALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", xVALID); end
    checks++; if (xIREG !== 32'h0) begin errors++; $display("FAIL rst_ireg: got %h want 0", xIREG); end
    checks++; if (rSKIP !== 1'b1) begin errors++; $display("FAIL rst_skip: got %b want 1", rSKIP); end
    checks++; if (rPC !== 30'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", rPC); end
    checks++; if ({rOPC, rRD, rRA, rRB, rALT} !== 32'h0 || rIMM !== 16'h0) begin
      errors++; $display("FAIL rst_fields: got %h/%h want 0", {rOPC, rRD, rRA, rRB, rALT}, rIMM); end
    iwb_ack = 1'b0;
    grst = 1'b1;
    @(negedge gclk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      checks++; if (iwb_stb !== 1'b1 || iwb_adr !== 30'(i)) begin
        errors++; $display("FAIL fill_req%0d: got stb=%b adr=%h want stb=1 adr=%h", i, iwb_stb, iwb_adr, i); end
      step(1'b0, 1'b0, 30'h0, 1'b1);
    end
    checks++; if (iwb_stb !== 1'b0) begin errors++; $display("FAIL fill_full_stb: got %b want 0", iwb_stb); end
    checks++; if (xVALID !== 1'b1 || xIREG !== wdat(30'h0)) begin
      errors++; $display("FAIL fill_head: got v=%b %h want v=1 %h", xVALID, xIREG, wdat(30'h0)); end
    step(1'b0, 1'b0, 30'h0, 1'b0);
    step(1'b0, 1'b0, 30'h0, 1'b0);
    checks++; if (iwb_stb !== 1'b0) begin errors++; $display("FAIL fill_idle_stb: got %b want 0", iwb_stb); end
  endtask

  task automatic test_pop();
    logic [31:0] w;
    w = wdat(30'h0);
    step(1'b1, 1'b0, 30'h0, 1'b0);
    checks++; if (rOPC !== w[31:26] || rRD !== w[25:21] || rRA !== w[20:16] || rRB !== w[15:11]) begin
      errors++; $display("FAIL pop_fields: got %h %h %h %h want %h %h %h %h", rOPC, rRD, rRA, rRB, w[31:26], w[25:21], w[20:16], w[15:11]); end
    checks++; if (rALT !== w[10:0] || rIMM !== w[15:0]) begin
      errors++; $display("FAIL pop_imm: got %h %h want %h %h", rALT, rIMM, w[10:0], w[15:0]); end
    checks++; if (rPC !== 30'h0 || rSKIP !== 1'b0) begin
      errors++; $display("FAIL pop_pc: got pc=%h skip=%b want 0 0", rPC, rSKIP); end
    checks++; if (iwb_stb !== 1'b1 || iwb_adr !== 30'h4) begin
      errors++; $display("FAIL pop_next_fetch: got stb=%b adr=%h want 1 4", iwb_stb, iwb_adr); end
    checks++; if (xIREG !== wdat(30'h1)) begin errors++; $display("FAIL pop_head: got %h want %h", xIREG, wdat(30'h1)); end
    step(1'b0, 1'b0, 30'h0, 1'b1);
    checks++; if (iwb_stb !== 1'b0) begin errors++; $display("FAIL pop_refill_stb: got %b want 0", iwb_stb); end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 30'h0, 1'b0);
      w = wdat(30'(i));
      checks++; if (rPC !== 30'(i) || rSKIP !== 1'b0 || rOPC !== w[31:26]) begin
        errors++; $display("FAIL drain%0d: got pc=%h skip=%b opc=%h want %h 0 %h", i, rPC, rSKIP, rOPC, i, w[31:26]); end
      checks++; if (iwb_stb !== 1'b1 || iwb_adr !== 30'h5) begin
        errors++; $display("FAIL drain_hold%0d: got stb=%b adr=%h want 1 5", i, iwb_stb, iwb_adr); end
    end
    checks++; if (xVALID !== 1'b0 || xIREG !== 32'h0) begin
      errors++; $display("FAIL drain_empty: got v=%b %h want 0 0", xVALID, xIREG); end
  endtask

  task automatic test_empty();
    logic [31:0] w;
    w = wdat(30'h4);
    step(1'b1, 1'b0, 30'h0, 1'b0);
    checks++; if (rSKIP !== 1'b1) begin errors++; $display("FAIL empty_skip: got %b want 1", rSKIP); end
    checks++; if (rPC !== 30'h4 || rOPC !== w[31:26] || rIMM !== w[15:0]) begin
      errors++; $display("FAIL empty_hold: got pc=%h opc=%h imm=%h want 4 %h %h", rPC, rOPC, rIMM, w[31:26], w[15:0]); end
  endtask

  task automatic test_drop();
    step(1'b0, 1'b1, 30'h100, 1'b0);
    checks++; if (rSKIP !== 1'b1) begin errors++; $display("FAIL drop_skip: got %b want 1", rSKIP); end
    checks++; if (iwb_stb !== 1'b1 || iwb_adr !== 30'h5) begin
      errors++; $display("FAIL drop_inflight: got stb=%b adr=%h want 1 5", iwb_stb, iwb_adr); end
    step(1'b0, 1'b0, 30'h0, 1'b1);
    checks++; if (xVALID !== 1'b0) begin errors++; $display("FAIL drop_discard: got v=%b want 0", xVALID); end
    checks++; if (iwb_stb !== 1'b1 || iwb_adr !== 30'h100) begin
      errors++; $display("FAIL drop_target: got stb=%b adr=%h want 1 100", iwb_stb, iwb_adr); end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 30'h3FFF_FFFF, 1'b1);
    checks++; if (xVALID !== 1'b0) begin errors++; $display("FAIL wrap_discard: got v=%b want 0", xVALID); end
    checks++; if (iwb_stb !== 1'b1 || iwb_adr !== 30'h3FFF_FFFF) begin
      errors++; $display("FAIL wrap_target: got stb=%b adr=%h want 1 3fffffff", iwb_stb, iwb_adr); end
    step(1'b0, 1'b0, 30'h0, 1'b1);
    checks++; if (xVALID !== 1'b1 || xIREG !== wdat(30'h3FFF_FFFF)) begin
      errors++; $display("FAIL wrap_push: got v=%b %h want 1 %h", xVALID, xIREG, wdat(30'h3FFF_FFFF)); end
    checks++; if (iwb_adr !== 30'h0) begin errors++; $display("FAIL wrap_adr: got %h want 0", iwb_adr); end
    step(1'b0, 1'b0, 30'h0, 1'b1);
    checks++; if (iwb_adr !== 30'h1 || xIREG !== wdat(30'h3FFF_FFFF)) begin
      errors++; $display("FAIL wrap_next: got adr=%h head=%h want 1 %h", iwb_adr, xIREG, wdat(30'h3FFF_FFFF)); end
  endtask

  task automatic test_retarget();
    step(1'b1, 1'b1, 30'h20, 1'b0);
    checks++; if (xVALID !== 1'b0 || rPC !== 30'h4 || rSKIP !== 1'b1) begin
      errors++; $display("FAIL bra_over_pop: got v=%b pc=%h skip=%b want 0 4 1", xVALID, rPC, rSKIP); end
    checks++; if (iwb_stb !== 1'b1 || iwb_adr !== 30'h1) begin
      errors++; $display("FAIL bra_hold: got stb=%b adr=%h want 1 1", iwb_stb, iwb_adr); end
    step(1'b0, 1'b1, 30'h40, 1'b0);
    checks++; if (iwb_adr !== 30'h1) begin errors++; $display("FAIL rebra_hold: got %h want 1", iwb_adr); end
    step(1'b0, 1'b0, 30'h0, 1'b1);
    checks++; if (xVALID !== 1'b0 || iwb_stb !== 1'b1 || iwb_adr !== 30'h40) begin
      errors++; $display("FAIL rebra_target: got v=%b stb=%b adr=%h want 0 1 40", xVALID, iwb_stb, iwb_adr); end
    step(1'b0, 1'b0, 30'h0, 1'b1);
    checks++; if (xVALID !== 1'b1 || xIREG !== wdat(30'h40) || iwb_adr !== 30'h41) begin
      errors++; $display("FAIL rebra_single_drop: got v=%b %h adr=%h want 1 %h 41", xVALID, xIREG, iwb_adr, wdat(30'h40)); end
    step(1'b1, 1'b0, 30'h0, 1'b0);
    checks++; if (rPC !== 30'h40 || rSKIP !== 1'b0) begin
      errors++; $display("FAIL rebra_decode: got pc=%h skip=%b want 40 0", rPC, rSKIP); end
  endtask

  task automatic test_reset_mid();
    grst = 1'b0;
    #1;
    checks++; if (iwb_stb !== 1'b0 || xVALID !== 1'b0 || rSKIP !== 1'b1 || rPC !== 30'h0) begin
      errors++; $display("FAIL midrst_async: got stb=%b v=%b skip=%b pc=%h want 0 0 1 0", iwb_stb, xVALID, rSKIP, rPC); end
    iwb_ack = 1'b1;
    repeat (2) @(negedge gclk);
    grst = 1'b1;
    @(negedge gclk);
    iwb_ack = 1'b0;
    checks++; if (iwb_stb !== 1'b1 || iwb_adr !== 30'h0 || xVALID !== 1'b0) begin
      errors++; $display("FAIL midrst_first: got stb=%b adr=%h v=%b want 1 0 0", iwb_stb, iwb_adr, xVALID); end
    step(1'b0, 1'b0, 30'h0, 1'b1);
    checks++; if (xVALID !== 1'b1 || xIREG !== wdat(30'h0) || iwb_adr !== 30'h1) begin
      errors++; $display("FAIL midrst_push: got v=%b %h adr=%h want 1 %h 1", xVALID, xIREG, iwb_adr, wdat(30'h0)); end
  endtask

  task automatic test_random();
    ent_t        mq[$];
    ent_t        e;
    logic [29:0] m_pc, m_iadr, m_rpc, t;
    logic [31:0] m_ir, head;
    logic        m_infl, m_drop, m_skip, d, b, a, acked;
    grst = 1'b0;
    repeat (2) @(negedge gclk);
    grst = 1'b1;
    m_pc = 30'h0; m_iadr = 30'h0; m_infl = 1'b0; m_drop = 1'b0;
    m_ir = '0; m_rpc = '0; m_skip = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      head = (mq.size() > 0) ? mq[0].d : 32'h0;
      checks++; if (iwb_stb !== m_infl) begin
        errors++; $display("FAIL rnd_stb c%0d: got %b want %b", cyc, iwb_stb, m_infl); end
      if (m_infl) begin
        checks++; if (iwb_adr !== m_iadr) begin
          errors++; $display("FAIL rnd_adr c%0d: got %h want %h", cyc, iwb_adr, m_iadr); end
      end
      checks++; if (xVALID !== (mq.size() > 0) || xIREG !== head) begin
        errors++; $display("FAIL rnd_head c%0d: got v=%b %h want v=%b %h", cyc, xVALID, xIREG, mq.size() > 0, head); end
      checks++; if (rSKIP !== m_skip || rPC !== m_rpc) begin
        errors++; $display("FAIL rnd_dec c%0d: got skip=%b pc=%h want %b %h", cyc, rSKIP, rPC, m_skip, m_rpc); end
      checks++; if ({rOPC, rRD, rRA, rRB} !== m_ir[31:11] || rALT !== m_ir[10:0] || rIMM !== m_ir[15:0]) begin
        errors++; $display("FAIL rnd_fields c%0d: got %h %h %h want %h", cyc, {rOPC, rRD, rRA, rRB}, rALT, rIMM, m_ir); end

      d = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFF - 30'($urandom_range(0, 2)) : 30'($urandom);
      a = ($urandom_range(0, 9) < 6);
      d_en = d; x_bra = b; x_tgt = t; iwb_ack = a;

      // Reference behaviour for the coming edge
      acked = m_infl && a;
      if (b) begin
        mq.delete();
        m_skip = 1'b1;
      end else if (d) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          m_ir = e.d; m_rpc = e.a; m_skip = 1'b0;
        end else begin
          m_skip = 1'b1;
        end
      end
      if (acked && !m_drop && !b) begin
        e.a = m_iadr; e.d = wdat(m_iadr);
        mq.push_back(e);
        m_pc = m_pc + 30'd1;
      end
      if (b) m_pc = t;
      if (acked)            m_drop = 1'b0;
      else if (b && m_infl) m_drop = 1'b1;
      if (!(m_infl && !a)) begin
        m_infl = (mq.size() < DEPTH) && !m_drop;
        if (m_infl) m_iadr = m_pc;
      end
      @(negedge gclk);
    end
    d_en = 1'b0; x_bra = 1'b0; iwb_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pop();
    test_empty();
    test_drop();
    test_wrap();
    test_retarget();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
